// File: rtl/frogger_tick_scheduler_pkg.sv
// Shared types for the Frogger tick scheduler: FSM state encoding and level width.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Width of the level register for the default four speed levels.
  localparam int LEVEL_W = 2;

endpackage

// File: rtl/frogger_tick_scheduler_lane_arbiter.sv
// Holds per-lane pending requests and grants the lowest-index one per enabled
// cycle, so the board-update write port sees at most one lane tick per cycle.
module tick_lane_arbiter #(
  parameter int NUM_LANES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] set_mask,
  input  logic                 enable,
  input  logic                 clear_all,
  output logic [NUM_LANES-1:0] lane_tick
);

  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] lane_tick_q;

  // Fixed priority: isolate the lowest set pending bit; a lane that is granted
  // and re-requested in the same cycle stays pending.
  always_comb begin
    grant = '0;
    if (enable) begin
      grant = pending_q & (~pending_q + 1'b1);
    end
    if (clear_all) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~grant) | set_mask;
    end
  end

  // Pending register and registered grant pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= '0;
      lane_tick_q <= '0;
    end else begin
      pending_q   <= pending_d;
      lane_tick_q <= grant;
    end
  end

  assign lane_tick = lane_tick_q;

endmodule

// File: rtl/frogger_tick_scheduler.sv
// Central timing controller: run/pause/over FSM, level-scaled base prescaler,
// per-lane divide-by-(i+1) counters feeding a single-grant lane arbiter.
module frogger_tick_scheduler
  import tick_pkg::*;
#(
  parameter int BASE_DIV   = 2**24,
  parameter int NUM_LANES  = 4,
  parameter int NUM_LEVELS = 2**LEVEL_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          level_up,
  input  logic                          game_over,
  output logic [NUM_LANES-1:0]          lane_tick,
  output logic                          base_tick,
  output logic [$clog2(NUM_LEVELS)-1:0] level,
  output logic [1:0]                    state
);

  localparam int LW = $clog2(NUM_LEVELS);
  localparam int CW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LW-1:0] LEVEL_MAX = LW'(NUM_LEVELS - 1);

  state_t                         state_q, state_d;
  logic [LW-1:0]                  level_q, level_d;
  logic [31:0]                    presc_q, presc_d;
  logic [31:0]                    period;
  logic                           wrap;
  logic                           base_tick_q;
  logic [NUM_LANES-1:0][CW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [NUM_LANES-1:0]           lane_wrap;
  logic                           clear_all;

  // Base period halves per level; compare with >= so a level change that
  // shrinks the period below the current count wraps on the next cycle.
  assign period = 32'(BASE_DIV) >> level_q;
  assign wrap   = (state_q == RUN) && (presc_q >= period - 32'd1);

  // Next-state and level logic; game_over beats pause beats level_up in RUN.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          level_d = '0;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (level_up && (level_q != LEVEL_MAX)) begin
          level_d = level_q + 1'b1;
        end
      end
      PAUSE: begin
        if (pause) state_d = RUN;
      end
      OVER: begin
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler counts in RUN, holds in PAUSE, clears otherwise.
  always_comb begin
    presc_d = presc_q;
    case (state_q)
      RUN:     presc_d = wrap ? 32'd0 : presc_q + 32'd1;
      PAUSE:   presc_d = presc_q;
      default: presc_d = 32'd0;
    endcase
  end

  // Lane i counts base ticks 0..i; its wrap raises a pending request.
  always_comb begin
    lane_wrap  = '0;
    lane_cnt_d = lane_cnt_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((state_q == IDLE) || (state_q == OVER)) begin
        lane_cnt_d[i] = '0;
      end else if (wrap) begin
        if (lane_cnt_q[i] == CW'(i)) begin
          lane_cnt_d[i] = '0;
          lane_wrap[i]  = 1'b1;
        end else begin
          lane_cnt_d[i] = lane_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pending requests are dropped as soon as the game leaves play.
  assign clear_all = (state_d == IDLE) || (state_d == OVER);

  // State, level, prescaler, lane counters and base tick pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      presc_q     <= '0;
      lane_cnt_q  <= '0;
      base_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      presc_q     <= presc_d;
      lane_cnt_q  <= lane_cnt_d;
      base_tick_q <= wrap;
    end
  end

  tick_lane_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arbiter (
    .clock     (clock),
    .reset     (reset),
    .set_mask  (lane_wrap),
    .enable    (state_q == RUN),
    .clear_all (clear_all),
    .lane_tick (lane_tick)
  );

  assign base_tick = base_tick_q;
  assign level     = level_q;
  assign state     = state_q;

endmodule

// File: tb/tb_frogger_tick_scheduler.sv
// Directed plus randomized bench for frogger_tick_scheduler with a cycle-level
// reference model built from base-tick counts and a pending-lane set.
module tb_frogger_tick_scheduler;

  localparam int BASE = 64;
  localparam int NL   = 4;
  localparam int NLV  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          level_up = 1'b0;
  logic          game_over = 1'b0;
  logic [NL-1:0] lane_tick;
  logic          base_tick;
  logic [1:0]    level;
  logic [1:0]    state;

  always #5 clock = ~clock;

  frogger_tick_scheduler #(
    .BASE_DIV   (BASE),
    .NUM_LANES  (NL),
    .NUM_LEVELS (NLV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .level_up  (level_up),
    .game_over (game_over),
    .lane_tick (lane_tick),
    .base_tick (base_tick),
    .level     (level),
    .state     (state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 over.
  int          m_state = 0;
  int          m_level = 0;
  int          m_presc = 0;
  int          m_nbt   = 0;
  bit [NL-1:0] m_pend  = '0;
  bit [NL-1:0] m_lane  = '0;
  bit          m_base  = 1'b0;
  int          n_base  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int          nst;
    bit          wrapped;
    bit [NL-1:0] g;
    if (reset) begin
      m_state = 0; m_level = 0; m_presc = 0; m_nbt = 0;
      m_pend = '0; m_lane = '0; m_base = 1'b0;
      return;
    end
    nst     = m_state;
    wrapped = 1'b0;
    g       = '0;
    m_base  = 1'b0;
    if (m_state == 1) begin
      if (m_presc >= (BASE >> m_level) - 1) begin
        m_presc = 0;
        wrapped = 1'b1;
      end else begin
        m_presc++;
      end
      for (int i = 0; i < NL; i++) begin
        if (m_pend[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
      m_pend = m_pend & ~g;
      if (wrapped) begin
        m_nbt++;
        m_base = 1'b1;
        for (int i = 0; i < NL; i++) if (m_nbt % (i + 1) == 0) m_pend[i] = 1'b1;
      end
    end
    m_lane = g;
    case (m_state)
      0: if (start) begin nst = 1; m_level = 0; end
      1: begin
        if (game_over) nst = 3;
        else if (pause) nst = 2;
        else if (level_up && m_level < NLV - 1) m_level++;
      end
      2: if (pause) nst = 1;
      3: if (start) nst = 0;
      default: nst = 0;
    endcase
    m_state = nst;
    if (nst == 0 || nst == 3) begin
      m_pend = '0; m_nbt = 0; m_presc = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("level", 32'(level), 32'(m_level));
    chk("base_tick", 32'(base_tick), 32'(m_base));
    chk("lane_tick", 32'(lane_tick), 32'(m_lane));
    chk("onehot0", 32'($onehot0(lane_tick)), 32'd1);
    if (base_tick) n_base++;
    start = 1'b0; pause = 1'b0; level_up = 1'b0; game_over = 1'b0;
  endtask

  task automatic wait_base(input string tag, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!base_tick && n < 300);
    if (!base_tick) begin
      errors++;
      $error("FAIL %s timeout observed no base_tick expected base_tick", tag);
    end
  endtask

  task automatic run_to_base_count(input int target);
    int guard;
    guard = 0;
    while (n_base < target && guard < 2000) begin
      cycle();
      guard++;
    end
    if (n_base < target) begin
      errors++;
      $error("FAIL base_count timeout observed %0d expected %0d", n_base, target);
    end
  endtask

  initial begin
    int first, cnt0, n, quiet, guard;
    bit [NL-1:0] snap, low;

    // 1: reset, start, 256 cycles of RUN at level 0.
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_lane", 32'(lane_tick), 32'd0);
    reset = 1'b0;
    start = 1'b1;
    cycle();
    n_base = 0;
    first = -1;
    cnt0 = 0;
    for (int k = 1; k <= 256; k++) begin
      cycle();
      if (base_tick && first < 0) first = k;
      if (lane_tick[0]) cnt0++;
    end
    chk("first_base", 32'(first), 32'd64);
    chk("base_count_256", 32'(n_base), 32'd4);
    chk("lane0_count_256", 32'(cnt0), 32'd3);

    // 2: all four lanes due on the 12th base tick.
    run_to_base_count(12);
    for (int j = 0; j < NL; j++) begin
      cycle();
      chk("burst", 32'(lane_tick), 32'(1 << j));
    end

    // 3: level ramp, mid-count period drop, saturation.
    level_up = 1'b1;
    cycle();
    chk("level_1", 32'(level), 32'd1);
    guard = 0;
    while (m_presc != 20 && guard < 100) begin cycle(); guard++; end
    level_up = 1'b1;
    cycle();
    chk("level_2", 32'(level), 32'd2);
    cycle();
    chk("shrink_wrap", 32'(base_tick), 32'd1);
    wait_base("period_16", n);
    chk("period_16", 32'(n), 32'd16);
    level_up = 1'b1;
    cycle();
    chk("level_3", 32'(level), 32'd3);
    wait_base("period_8a", n);
    wait_base("period_8", n);
    chk("period_8", 32'(n), 32'd8);
    level_up = 1'b1;
    cycle();
    chk("level_sat", 32'(level), 32'd3);

    // 4: pause while lanes pending, hold, resume.
    guard = 0;
    do begin cycle(); guard++; end
    while (!(base_tick && $countones(m_pend) >= 2) && guard < 500);
    pause = 1'b1;
    cycle();
    chk("pause_state", 32'(state), 32'd2);
    snap = m_pend;
    quiet = 0;
    for (int k = 0; k < 99; k++) begin
      cycle();
      if (base_tick || lane_tick != '0) quiet++;
    end
    chk("pause_quiet", 32'(quiet), 32'd0);
    pause = 1'b1;
    cycle();
    chk("resume_state", 32'(state), 32'd1);
    cycle();
    low = '0;
    for (int i = NL - 1; i >= 0; i--) if (snap[i]) low = NL'(1 << i);
    chk("resume_first", 32'(lane_tick), 32'(low));

    // 5: game_over beats pause; OVER -> IDLE -> RUN restarts cleanly.
    game_over = 1'b1;
    pause = 1'b1;
    cycle();
    chk("over_state", 32'(state), 32'd3);
    quiet = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (base_tick || lane_tick != '0) quiet++;
    end
    chk("over_quiet", 32'(quiet), 32'd0);
    start = 1'b1;
    cycle();
    chk("over_to_idle", 32'(state), 32'd0);
    start = 1'b1;
    cycle();
    chk("restart_run", 32'(state), 32'd1);
    chk("restart_level", 32'(level), 32'd0);
    wait_base("restart_period", n);
    chk("restart_period", 32'(n), 32'd64);

    // Randomized pulses checked against the model.
    for (int k = 0; k < 2500; k++) begin
      start     = ($urandom_range(0, 63) == 0);
      pause     = ($urandom_range(0, 47) == 0);
      level_up  = ($urandom_range(0, 31) == 0);
      game_over = ($urandom_range(0, 199) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      cycle();
      reset = 1'b0;
    end

    // 6: reset in the middle of the 12-tick burst.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    start = 1'b1;
    cycle();
    n_base = 0;
    run_to_base_count(12);
    cycle();
    chk("pre_reset_burst", 32'(lane_tick), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_lane", 32'(lane_tick), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    start = 1'b1;
    cycle();
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (lane_tick != '0) quiet++;
    end
    chk("pending_cleared", 32'(quiet), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
